// File: rtl/control_unit.sv
// control_unit: registered main decoder for the MIPS-subset datapath.
// Maps the 6-bit opcode to write-back select, register write enable,
// ALU operation class and ALU operand-B source, with one clock of latency.
// Optional build macro CU_ILLEGAL_TRAP_EN adds a registered illegal_op flag
// that is high for one decode whenever an opcode outside the table is sampled.
module control_unit #(
    parameter int                  OPCODE_W      = 6,
    parameter logic [OPCODE_W-1:0] CUSTOM_OPCODE = 6'b111111
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                write_data_select,
    output logic                reg_write,
    output logic                alu_op,
    output logic                alu_select
`ifdef CU_ILLEGAL_TRAP_EN
    ,
    output logic                illegal_op
`endif
);

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;

    logic write_data_select_d, write_data_select_q;
    logic reg_write_d,         reg_write_q;
    logic alu_op_d,            alu_op_q;
    logic alu_select_d,        alu_select_q;
    logic illegal_d,           illegal_q;

    // Combinational decode; unmatched opcodes (including X/Z in simulation) fall to NOP.
    always_comb begin
        write_data_select_d = 1'b0;
        reg_write_d         = 1'b0;
        alu_op_d            = 1'b0;
        alu_select_d        = 1'b0;
        illegal_d           = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_write_d = 1'b1;
                alu_op_d    = 1'b1;
            end
            OP_ADDI: begin
                reg_write_d  = 1'b1;
                alu_select_d = 1'b1;
            end
            OP_LW: begin
                write_data_select_d = 1'b1;
                reg_write_d         = 1'b1;
                alu_select_d        = 1'b1;
            end
            OP_SW: begin
                alu_select_d = 1'b1;
            end
            OP_BEQ: begin
                // Compare goes through the funct-class ALU path; branch resolution is elsewhere.
                alu_op_d = 1'b1;
            end
            CUSTOM_OPCODE: begin
                // LWI behaves like LW on the control side.
                write_data_select_d = 1'b1;
                reg_write_d         = 1'b1;
                alu_select_d        = 1'b1;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    // Output registers: cleared asynchronously, then load the decode every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_data_select_q <= 1'b0;
            reg_write_q         <= 1'b0;
            alu_op_q            <= 1'b0;
            alu_select_q        <= 1'b0;
            illegal_q           <= 1'b0;
        end else begin
            write_data_select_q <= write_data_select_d;
            reg_write_q         <= reg_write_d;
            alu_op_q            <= alu_op_d;
            alu_select_q        <= alu_select_d;
            illegal_q           <= illegal_d;
        end
    end

    assign write_data_select = write_data_select_q;
    assign reg_write         = reg_write_q;
    assign alu_op            = alu_op_q;
    assign alu_select        = alu_select_q;

`ifdef CU_ILLEGAL_TRAP_EN
    assign illegal_op = illegal_q;
`else
    // Without the trap the flag register is dropped by synthesis; keep it referenced.
    logic unused_illegal;
    assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: table-driven decode vectors plus hand-written
// sequences for asynchronous reset, between-edge opcode changes and LWI streams.
`timescale 1ns/1ps
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       write_data_select;
    logic       reg_write;
    logic       alu_op;
    logic       alu_select;
`ifdef CU_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int n_cmp;
    int n_fail;

    control_unit #(
        .OPCODE_W      (6),
        .CUSTOM_OPCODE (6'b111111)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .opcode            (opcode),
        .write_data_select (write_data_select),
        .reg_write         (reg_write),
        .alu_op            (alu_op),
        .alu_select        (alu_select)
`ifdef CU_ILLEGAL_TRAP_EN
        ,
        .illegal_op        (illegal_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [3:0] ctl;   // {write_data_select, reg_write, alu_op, alu_select}
        logic       ill;
    } vec_t;

    vec_t vecs [14];

    // Compare the four controls against the expected pattern.
    task automatic chk(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = {write_data_select, reg_write, alu_op, alu_select};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: controls got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Compare the illegal flag (only exists in the trap build).
    task automatic chk_ill(input string name, input logic exp);
`ifdef CU_ILLEGAL_TRAP_EN
        n_cmp++;
        if (illegal_op !== exp) begin
            n_fail++;
            $display("FAIL %s: illegal_op got %b expected %b at %0t", name, illegal_op, exp, $time);
        end
`else
        if (exp === 1'bx) $display("unused %s", name);
`endif
    endtask

    // Present an opcode mid-cycle and wait until just after the next rising edge.
    task automatic step(input logic [5:0] op);
        @(negedge clk);
        opcode = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        vecs[0]  = '{"rtype",    6'b000000, 4'b0110, 1'b0};
        vecs[1]  = '{"addi",     6'b001000, 4'b0101, 1'b0};
        vecs[2]  = '{"lw",       6'b100011, 4'b1101, 1'b0};
        vecs[3]  = '{"sw",       6'b101011, 4'b0001, 1'b0};
        vecs[4]  = '{"beq",      6'b000100, 4'b0010, 1'b0};
        vecs[5]  = '{"lwi",      6'b111111, 4'b1101, 1'b0};
        vecs[6]  = '{"ill_15",   6'b010101, 4'b0000, 1'b1};
        vecs[7]  = '{"rtype2",   6'b000000, 4'b0110, 1'b0};
        vecs[8]  = '{"ill_j",    6'b000010, 4'b0000, 1'b1};
        vecs[9]  = '{"ill_3e",   6'b111110, 4'b0000, 1'b1};
        vecs[10] = '{"ill_bne",  6'b000101, 4'b0000, 1'b1};
        vecs[11] = '{"lwi2",     6'b111111, 4'b1101, 1'b0};
        vecs[12] = '{"ill_sb",   6'b101000, 4'b0000, 1'b1};
        vecs[13] = '{"addi2",    6'b001000, 4'b0101, 1'b0};

        // Reset state with opcode R-type present
        rst_n  = 1'b0;
        opcode = 6'b000000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", 4'b0000);
        chk_ill("reset_hold_ill", 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_after_reset", 4'b0110);

        // Asynchronous assert mid-cycle: outputs clear without a clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_rtype", 4'b0000);
        @(posedge clk);
        #1;
        chk("reset_across_edge", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_rtype", 4'b0110);

        // R-type then LWI on consecutive edges
        step(6'b000000);
        chk("seq_rtype", 4'b0110);
        step(6'b111111);
        chk("seq_lwi", 4'b1101);

        // Table sweep, one opcode per cycle
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].op);
            chk(vecs[i].name, vecs[i].ctl);
            chk_ill(vecs[i].name, vecs[i].ill);
            if (vecs[i].ill) begin
                n_cmp++;
                if (reg_write !== 1'b0) begin
                    n_fail++;
                    $display("FAIL regwr_on_illegal %s: got %b expected 0", vecs[i].name, reg_write);
                end
            end
        end

        // Opcode changed between edges: outputs hold until the next rising edge
        step(6'b000000);
        chk("hold_pre", 4'b0110);
        @(negedge clk);
        opcode = 6'b100011;
        #2;
        chk("hold_between_edges", 4'b0110);
        opcode = 6'b101011;
        #1;
        chk("hold_second_change", 4'b0110);
        @(posedge clk);
        #1;
        chk("hold_update", 4'b0001);

        // Reset asserted during an LWI stream
        step(6'b111111);
        step(6'b111111);
        chk("lwi_stream", 4'b1101);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("lwi_async_reset", 4'b0000);
        n_cmp++;
        if (reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL regwr_in_reset: got %b expected 0", reg_write);
        end
        @(posedge clk);
        #1;
        chk("lwi_reset_held", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("lwi_resume", 4'b1101);
        chk_ill("lwi_resume_ill", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
